// File: rtl/mem_port_arbiter_if.sv
// Bundle of the instruction port, data port and memory port seen by mem_port_arbiter.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_rdata;
    logic              i_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [2:0]        d_mask;
    logic [31:0]       d_rdata;
    logic              d_ack;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;
    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_mask, mem_rdata,
        output i_rdata, i_ack, d_rdata, d_ack,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_mask, mem_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between instruction fetch and data access.
// Define MEM_RMW_EN to build sub-word stores as read-modify-write; otherwise they use lane strobes.
module mem_port_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     bus,
    output logic [1:0]            o_dbg_state
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_RESP = 2'd1,
        D_RESP = 2'd2,
        RMW_WR = 2'd3
    } state_t;

    state_t r_state;
    logic   r_pri_i;
    logic   r_is_load;
`ifdef MEM_RMW_EN
    logic [ADDR_W-3:0] r_addr;
    logic [15:0]       r_wdata;
    logic [1:0]        r_lane;
    logic              r_half;
`endif

    logic              w_grant_d;
    logic              w_grant_i;
    logic              w_sub;
    logic              w_half;
    logic              w_en;
    logic              w_we;
    logic [ADDR_W-3:0] w_addr;
    logic [31:0]       w_wdata;
    logic [3:0]        w_wstrb;
    logic              w_unused_ok;

    // Requesters hold req until a one-cycle ack; IDLE only ever sees fresh requests.
    assign w_grant_d   = bus.d_req && (!bus.i_req || !r_pri_i);
    assign w_grant_i   = bus.i_req && !w_grant_d;
    assign w_sub       = (bus.d_mask == 3'h0) || (bus.d_mask == 3'h1);
    assign w_half      = (bus.d_mask == 3'h1);
    assign w_unused_ok = &{1'b0, bus.i_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pri_i   <= 1'b0;
            r_is_load <= 1'b0;
`ifdef MEM_RMW_EN
            r_addr    <= '0;
            r_wdata   <= '0;
            r_lane    <= '0;
            r_half    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_is_load <= !bus.d_we;
`ifdef MEM_RMW_EN
                        r_addr    <= bus.d_addr[ADDR_W-1:2];
                        r_wdata   <= bus.d_wdata[15:0];
                        r_lane    <= bus.d_addr[1:0];
                        r_half    <= w_half;
                        r_state   <= (bus.d_we && w_sub) ? RMW_WR : D_RESP;
`else
                        r_state   <= D_RESP;
`endif
                    end else if (w_grant_i) begin
                        r_state <= I_RESP;
                    end
                end
`ifdef MEM_RMW_EN
                RMW_WR: r_state <= D_RESP;
`endif
                D_RESP: begin
                    if (bus.i_req) r_pri_i <= 1'b1;
                    r_state <= IDLE;
                end
                I_RESP: begin
                    r_pri_i <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_en    = 1'b0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_wstrb = '0;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_en   = 1'b1;
                    w_addr = bus.d_addr[ADDR_W-1:2];
                    if (bus.d_we) begin
`ifdef MEM_RMW_EN
                        if (!w_sub) begin
                            w_we    = 1'b1;
                            w_wdata = bus.d_wdata;
                            w_wstrb = 4'hF;
                        end
`else
                        w_we = 1'b1;
                        if (!w_sub) begin
                            w_wdata = bus.d_wdata;
                            w_wstrb = 4'hF;
                        end else if (w_half) begin
                            w_wdata = {2{bus.d_wdata[15:0]}};
                            w_wstrb = 4'b0011 << {bus.d_addr[1], 1'b0};
                        end else begin
                            w_wdata = {4{bus.d_wdata[7:0]}};
                            w_wstrb = 4'b0001 << bus.d_addr[1:0];
                        end
`endif
                    end
                end else if (w_grant_i) begin
                    w_en   = 1'b1;
                    w_addr = bus.i_addr[ADDR_W-1:2];
                end
            end
`ifdef MEM_RMW_EN
            RMW_WR: begin
                w_en    = 1'b1;
                w_we    = 1'b1;
                w_addr  = r_addr;
                w_wstrb = 4'hF;
                w_wdata = bus.mem_rdata;
                if (r_half) w_wdata[{r_lane[1], 4'b0000} +: 16] = r_wdata;
                else        w_wdata[{r_lane, 3'b000} +: 8]      = r_wdata[7:0];
            end
`endif
            default: ;
        endcase
        // Reset wins over everything, including a pending read-modify-write.
        if (rst) begin
            w_en    = 1'b0;
            w_we    = 1'b0;
            w_addr  = '0;
            w_wdata = '0;
            w_wstrb = '0;
        end
    end

    assign bus.mem_en    = w_en;
    assign bus.mem_we    = w_we;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = w_wdata;
    assign bus.mem_wstrb = w_wstrb;
    assign bus.d_ack     = !rst && (r_state == D_RESP);
    assign bus.d_rdata   = (bus.d_ack && r_is_load) ? bus.mem_rdata : 32'h0;
    assign bus.i_ack     = !rst && (r_state == I_RESP);
    assign bus.i_rdata   = bus.i_ack ? bus.mem_rdata : 32'h0;
    assign bus.busy      = !rst && (r_state != IDLE);
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: load, sub-word and odd-mask stores, alternation, reset abort.
// Expectations for sub-word stores follow the MEM_RMW_EN build setting.
module tb_mem_port_arbiter;
    logic       clk;
    logic       rst;
    logic [1:0] dbg;
    int         total;
    int         bad;

    mem_port_arbiter_if #(.ADDR_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here, checks follow #1 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_mask = 3'h2;
        bus.mem_rdata = '0;
        tick();
        tick();

        // Reset holds everything quiet even with a request pending
        bus.d_req = 1'b1; bus.d_addr = 32'h100;
        settle();
        chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("rst_busy",   {31'd0, bus.busy},   32'd0);
        chk("rst_d_ack",  {31'd0, bus.d_ack},  32'd0);
        chk("rst_state",  {30'd0, dbg},        32'd0);

        // Load from 0x100
        tick();
        rst = 1'b0;
        settle();
        chk("ld_mem_en",   {31'd0, bus.mem_en}, 32'd1);
        chk("ld_mem_we",   {31'd0, bus.mem_we}, 32'd0);
        chk("ld_mem_addr", bus.mem_addr,        32'h40);
        chk("ld_busy0",    {31'd0, bus.busy},   32'd0);
        tick();
        bus.mem_rdata = 32'hDEADBEEF;
        settle();
        chk("ld_d_ack",   {31'd0, bus.d_ack},  32'd1);
        chk("ld_d_rdata", bus.d_rdata,         32'hDEADBEEF);
        chk("ld_en_resp", {31'd0, bus.mem_en}, 32'd0);
        chk("ld_busy1",   {31'd0, bus.busy},   32'd1);
        tick();
        bus.d_req = 1'b0;
        settle();
        chk("ld_idle_ack",  {31'd0, bus.d_ack}, 32'd0);
        chk("ld_idle_busy", {31'd0, bus.busy},  32'd0);

        // Byte store of 0xAA to 0x103, old word 0x11223344
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h103; bus.d_wdata = 32'h000000AA;
        bus.d_mask = 3'h0; bus.mem_rdata = 32'h11223344;
        settle();
        chk("sb_addr", bus.mem_addr, 32'h40);
`ifdef MEM_RMW_EN
        chk("sb_rd_en", {31'd0, bus.mem_en}, 32'd1);
        chk("sb_rd_we", {31'd0, bus.mem_we}, 32'd0);
        tick();
        settle();
        chk("sb_wr_en",    {31'd0, bus.mem_en}, 32'd1);
        chk("sb_wr_we",    {31'd0, bus.mem_we}, 32'd1);
        chk("sb_wr_data",  bus.mem_wdata,       32'hAA223344);
        chk("sb_wr_strb",  {28'd0, bus.mem_wstrb}, 32'hF);
        chk("sb_wr_noack", {31'd0, bus.d_ack},  32'd0);
`else
        chk("sb_en",   {31'd0, bus.mem_en},    32'd1);
        chk("sb_we",   {31'd0, bus.mem_we},    32'd1);
        chk("sb_data", bus.mem_wdata,          32'hAAAAAAAA);
        chk("sb_strb", {28'd0, bus.mem_wstrb}, 32'h8);
`endif
        tick();
        settle();
        chk("sb_ack",   {31'd0, bus.d_ack},  32'd1);
        chk("sb_rdata", bus.d_rdata,         32'd0);
        chk("sb_en_rs", {31'd0, bus.mem_en}, 32'd0);
        tick();
        bus.d_req = 1'b0;

        // Store with mask 5 behaves as a full word store
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h8; bus.d_wdata = 32'h12345678;
        bus.d_mask = 3'h5;
        settle();
        chk("m5_we",   {31'd0, bus.mem_we},    32'd1);
        chk("m5_addr", bus.mem_addr,           32'h2);
        chk("m5_data", bus.mem_wdata,          32'h12345678);
        chk("m5_strb", {28'd0, bus.mem_wstrb}, 32'hF);
        tick();
        settle();
        chk("m5_ack", {31'd0, bus.d_ack}, 32'd1);
        tick();
        bus.d_req = 1'b0;

        // Both ports held from reset: grants alternate D, I, D, I, D
        rst = 1'b1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20; bus.d_mask = 3'h2;
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        bus.mem_rdata = 32'hCAFEF00D;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("alt_d_addr", bus.mem_addr, 32'h8);
            tick();
            settle();
            chk("alt_d_ack", {bus.i_ack, bus.d_ack}, 32'd1);
            tick();
            settle();
            chk("alt_i_addr", bus.mem_addr, 32'h4);
            tick();
            settle();
            chk("alt_i_ack",   {bus.i_ack, bus.d_ack}, 32'd2);
            chk("alt_i_rdata", bus.i_rdata,           32'hCAFEF00D);
            tick();
        end
        settle();
        chk("alt_d3_addr", bus.mem_addr, 32'h8);
        tick();
        settle();
        chk("alt_d3_ack", {bus.i_ack, bus.d_ack}, 32'd1);
        tick();
        bus.d_req = 1'b0; bus.i_req = 1'b0;

        // Half store to 0x202, reset lands during the store; instruction priority is now pending
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h202; bus.d_wdata = 32'h0000BEEF;
        bus.d_mask = 3'h1;
        settle();
        chk("hs_addr", bus.mem_addr, 32'h80);
`ifdef MEM_RMW_EN
        chk("hs_rd_we", {31'd0, bus.mem_we}, 32'd0);
`else
        chk("hs_data", bus.mem_wdata,          32'hBEEFBEEF);
        chk("hs_strb", {28'd0, bus.mem_wstrb}, 32'hC);
`endif
        tick();
        rst = 1'b1;
        settle();
        chk("hs_rst_en",   {31'd0, bus.mem_en},    32'd0);
        chk("hs_rst_strb", {28'd0, bus.mem_wstrb}, 32'd0);
        chk("hs_rst_ack",  {31'd0, bus.d_ack},     32'd0);
        chk("hs_rst_busy", {31'd0, bus.busy},      32'd0);
        tick();
        rst = 1'b0;
        bus.d_req = 1'b0;
        settle();
        chk("hs_idle", {30'd0, dbg}, 32'd0);

        // Priority was cleared by reset: data wins a simultaneous request
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h30; bus.d_mask = 3'h2;
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        settle();
        chk("pri_rst_addr", bus.mem_addr, 32'hC);
        tick();
        bus.d_req = 1'b0; bus.i_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
